// File: rtl/lcd_hex_driver.sv
// lcd_hex_driver
// Drives an HD44780-compatible character LCD over its 4-bit bus and keeps
// redrawing a 32-bit value as 8 uppercase hex digits at line 1, column 0.
// After reset it waits for LCD power-up, runs the 4-bit init nibbles and the
// configuration commands, then loops forever: set DDRAM address 0x80, write
// 8 characters, pulse frame_done, repeat.
// All LCD timing comes from cycle-count parameters.
// Ports:
//   CCLK       in   system clock
//   rst        in   synchronous active-high reset
//   disp_num   in   32-bit value to display, sampled once per frame
//   LCDRS      out  register select (0 = command, 1 = data)
//   LCDRW      out  read/write, always 0 (write only)
//   LCDE       out  enable strobe
//   LCDDAT     out  data nibble D7..D4
//   init_done  out  high once init/config has completed, until reset
//   frame_done out  one-cycle pulse after the last character of a frame
module lcd_hex_driver #(
    parameter int unsigned T_POWERUP = 750000,
    parameter int unsigned T_INIT1   = 205000,
    parameter int unsigned T_INIT2   = 5000,
    parameter int unsigned T_SETUP   = 2,
    parameter int unsigned T_E_HIGH  = 12,
    parameter int unsigned T_NGAP    = 50,
    parameter int unsigned T_CMD     = 2000,
    parameter int unsigned T_CLEAR   = 82000
) (
    input  logic        CCLK,
    input  logic        rst,
    input  logic [31:0] disp_num,
    output logic        LCDRS,
    output logic        LCDRW,
    output logic        LCDE,
    output logic [3:0]  LCDDAT,
    output logic        init_done,
    output logic        frame_done
);

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    localparam int unsigned T_EH  = (T_E_HIGH == 32'd0) ? 32'd1 : T_E_HIGH;
    localparam int unsigned T_MAX = max2(max2(max2(T_POWERUP, T_INIT1), max2(T_INIT2, T_SETUP)),
                                         max2(max2(T_EH, T_NGAP), max2(T_CMD, T_CLEAR)));
    localparam int unsigned CW    = (T_MAX < 32'd2) ? 32'd1 : $clog2(T_MAX + 32'd1);

    localparam logic [CW-1:0] ZERO      = {CW{1'b0}};
    localparam logic [CW-1:0] ONE       = CW'(32'd1);
    localparam logic [CW-1:0] L_POWERUP = CW'(T_POWERUP);
    localparam logic [CW-1:0] L_INIT1   = CW'(T_INIT1);
    localparam logic [CW-1:0] L_INIT2   = CW'(T_INIT2);
    localparam logic [CW-1:0] L_SETUP   = CW'(T_SETUP);
    localparam logic [CW-1:0] L_E_HIGH  = CW'(T_EH);
    localparam logic [CW-1:0] L_NGAP    = CW'(T_NGAP);
    localparam logic [CW-1:0] L_CMD     = CW'(T_CMD);
    localparam logic [CW-1:0] L_CLEAR   = CW'(T_CLEAR);

    // A phase of length len ends in the cycle its counter reaches len-1.
    // Length 0 behaves like length 1 here; the gap and settle phases are
    // skipped outright when their length is 0.
    function automatic logic phase_last(input logic [CW-1:0] cnt, input logic [CW-1:0] len);
        return (len == ZERO) || (cnt == (len - ONE));
    endfunction

    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        if (n < 4'd10) begin
            return 8'h30 + {4'h0, n};
        end else begin
            return 8'h37 + {4'h0, n};
        end
    endfunction

    function automatic logic [7:0] cfg_byte(input logic [2:0] idx);
        case (idx)
            3'd0:    return 8'h28;
            3'd1:    return 8'h06;
            3'd2:    return 8'h0C;
            default: return 8'h01;
        endcase
    endfunction

    typedef enum logic [2:0] {
        N_IDLE  = 3'd0,
        N_SETUP = 3'd1,
        N_EHIGH = 3'd2,
        N_GAP   = 3'd3,
        N_WAIT  = 3'd4
    } nib_state_e;

    typedef enum logic [3:0] {
        PWR_WAIT = 4'd0,
        INIT_A   = 4'd1,
        INIT_B   = 4'd2,
        INIT_C   = 4'd3,
        INIT_D   = 4'd4,
        CFG      = 4'd5,
        SET_ADDR = 4'd6,
        WRITE    = 4'd7
    } main_state_e;

    // transfer engine state
    nib_state_e    nstate_q, nstate_d;
    logic [CW-1:0] ncnt_q, ncnt_d;
    logic          lo_q, lo_d;
    logic          is_byte_q, is_byte_d;
    logic [7:0]    byte_q, byte_d;
    logic [CW-1:0] wait_q, wait_d;
    logic          lcdrs_q, lcdrs_d;
    logic [3:0]    lcddat_q, lcddat_d;
    logic          lcde_q, lcde_d;
    logic          leave_gap_s;
    logic          nib_done_s;

    // sequencer state
    main_state_e   state_q, state_d;
    logic [CW-1:0] pcnt_q, pcnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [31:0]   shadow_q, shadow_d;
    logic          init_done_q, init_done_d;
    logic          frame_done_q, frame_done_d;
    logic          start_s;
    logic          req_rs_s;
    logic          req_is_byte_s;
    logic [7:0]    req_byte_s;
    logic [CW-1:0] req_wait_s;

    // Transfer engine: setup, strobe, post-strobe gap per nibble, then settle wait.
    always_comb begin
        nstate_d    = nstate_q;
        ncnt_d      = ncnt_q + ONE;
        lo_d        = lo_q;
        is_byte_d   = is_byte_q;
        byte_d      = byte_q;
        wait_d      = wait_q;
        lcdrs_d     = lcdrs_q;
        lcddat_d    = lcddat_q;
        leave_gap_s = 1'b0;
        nib_done_s  = 1'b0;
        case (nstate_q)
            N_IDLE: begin
                ncnt_d = ZERO;
                if (start_s) begin
                    nstate_d  = N_SETUP;
                    lo_d      = 1'b0;
                    is_byte_d = req_is_byte_s;
                    byte_d    = req_byte_s;
                    wait_d    = req_wait_s;
                    lcdrs_d   = req_rs_s;
                    lcddat_d  = req_byte_s[7:4];
                end else begin
                    nstate_d = N_IDLE;
                end
            end
            N_SETUP: begin
                if (phase_last(ncnt_q, L_SETUP)) begin
                    nstate_d = N_EHIGH;
                    ncnt_d   = ZERO;
                end else begin
                    nstate_d = N_SETUP;
                end
            end
            N_EHIGH: begin
                if (!phase_last(ncnt_q, L_E_HIGH)) begin
                    nstate_d = N_EHIGH;
                end else if (L_NGAP == ZERO) begin
                    leave_gap_s = 1'b1;
                end else begin
                    nstate_d = N_GAP;
                    ncnt_d   = ZERO;
                end
            end
            N_GAP: begin
                if (phase_last(ncnt_q, L_NGAP)) begin
                    leave_gap_s = 1'b1;
                end else begin
                    nstate_d = N_GAP;
                end
            end
            N_WAIT: begin
                if (phase_last(ncnt_q, wait_q)) begin
                    nstate_d   = N_IDLE;
                    nib_done_s = 1'b1;
                end else begin
                    nstate_d = N_WAIT;
                end
            end
            default: begin
                nstate_d = N_IDLE;
            end
        endcase

        // after the gap: low nibble of a byte, then settle wait, then done
        if (leave_gap_s) begin
            ncnt_d = ZERO;
            if (is_byte_q && !lo_q) begin
                nstate_d = N_SETUP;
                lo_d     = 1'b1;
                lcddat_d = byte_q[3:0];
            end else if (wait_q != ZERO) begin
                nstate_d = N_WAIT;
            end else begin
                nstate_d   = N_IDLE;
                nib_done_s = 1'b1;
            end
        end else begin
            nib_done_s = nib_done_s;
        end

        lcde_d = (nstate_d == N_EHIGH);
    end

    // Sequencer: power-up wait, init nibbles, config bytes, then the frame loop.
    always_comb begin
        state_d       = state_q;
        pcnt_d        = pcnt_q;
        idx_d         = idx_q;
        shadow_d      = shadow_q;
        init_done_d   = init_done_q;
        frame_done_d  = 1'b0;
        start_s       = (nstate_q == N_IDLE) && (state_q != PWR_WAIT);
        req_rs_s      = 1'b0;
        req_is_byte_s = 1'b1;
        req_byte_s    = 8'h00;
        req_wait_s    = L_CMD;
        case (state_q)
            PWR_WAIT: begin
                if (phase_last(pcnt_q, L_POWERUP)) begin
                    state_d = INIT_A;
                    pcnt_d  = ZERO;
                end else begin
                    pcnt_d = pcnt_q + ONE;
                end
            end
            INIT_A: begin
                req_is_byte_s = 1'b0;
                req_byte_s    = 8'h30;
                req_wait_s    = L_INIT1;
                if (nib_done_s) begin state_d = INIT_B; end else begin state_d = INIT_A; end
            end
            INIT_B: begin
                req_is_byte_s = 1'b0;
                req_byte_s    = 8'h30;
                req_wait_s    = L_INIT2;
                if (nib_done_s) begin state_d = INIT_C; end else begin state_d = INIT_B; end
            end
            INIT_C: begin
                req_is_byte_s = 1'b0;
                req_byte_s    = 8'h30;
                if (nib_done_s) begin state_d = INIT_D; end else begin state_d = INIT_C; end
            end
            INIT_D: begin
                req_is_byte_s = 1'b0;
                req_byte_s    = 8'h20;
                if (nib_done_s) begin
                    state_d = CFG;
                    idx_d   = 3'd0;
                end else begin
                    state_d = INIT_D;
                end
            end
            CFG: begin
                req_byte_s = cfg_byte(idx_q);
                req_wait_s = (req_byte_s == 8'h01) ? L_CLEAR : L_CMD;
                if (nib_done_s && (idx_q == 3'd3)) begin
                    state_d     = SET_ADDR;
                    idx_d       = 3'd0;
                    init_done_d = 1'b1;
                end else if (nib_done_s) begin
                    idx_d = idx_q + 3'd1;
                end else begin
                    idx_d = idx_q;
                end
            end
            SET_ADDR: begin
                req_byte_s = 8'h80;
                // the frame's value is frozen when its address command starts
                if (start_s) begin
                    shadow_d = disp_num;
                end else begin
                    shadow_d = shadow_q;
                end
                if (nib_done_s) begin
                    state_d = WRITE;
                    idx_d   = 3'd0;
                end else begin
                    state_d = SET_ADDR;
                end
            end
            WRITE: begin
                req_rs_s   = 1'b1;
                // idx 0 selects bits 31:28, idx 7 selects bits 3:0
                req_byte_s = hex_ascii(shadow_q[{~idx_q, 2'b00} +: 4]);
                if (nib_done_s && (idx_q == 3'd7)) begin
                    state_d      = SET_ADDR;
                    idx_d        = 3'd0;
                    frame_done_d = 1'b1;
                end else if (nib_done_s) begin
                    idx_d = idx_q + 3'd1;
                end else begin
                    idx_d = idx_q;
                end
            end
            default: begin
                state_d = PWR_WAIT;
                pcnt_d  = ZERO;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge CCLK) begin
        if (rst) begin
            nstate_q     <= N_IDLE;
            ncnt_q       <= ZERO;
            lo_q         <= 1'b0;
            is_byte_q    <= 1'b0;
            byte_q       <= 8'h00;
            wait_q       <= ZERO;
            lcdrs_q      <= 1'b0;
            lcddat_q     <= 4'h0;
            lcde_q       <= 1'b0;
            state_q      <= PWR_WAIT;
            pcnt_q       <= ZERO;
            idx_q        <= 3'd0;
            shadow_q     <= 32'h0000_0000;
            init_done_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            nstate_q     <= nstate_d;
            ncnt_q       <= ncnt_d;
            lo_q         <= lo_d;
            is_byte_q    <= is_byte_d;
            byte_q       <= byte_d;
            wait_q       <= wait_d;
            lcdrs_q      <= lcdrs_d;
            lcddat_q     <= lcddat_d;
            lcde_q       <= lcde_d;
            state_q      <= state_d;
            pcnt_q       <= pcnt_d;
            idx_q        <= idx_d;
            shadow_q     <= shadow_d;
            init_done_q  <= init_done_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign LCDRS      = lcdrs_q;
    assign LCDRW      = 1'b0;
    assign LCDE       = lcde_q;
    assign LCDDAT     = lcddat_q;
    assign init_done  = init_done_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_lcd_hex_driver.sv
// tb_lcd_hex_driver
// Self-checking bench for lcd_hex_driver with shrunk timing. A monitor
// captures every LCDE strobe (RS, nibble, rise and fall cycle) and checks
// bus stability; the main sequence decodes the strobes into init nibbles,
// command bytes and characters and compares them with a model derived from
// the displayed values, using random display values.
module tb_lcd_hex_driver;

    logic        CCLK = 1'b0;
    logic        rst  = 1'b1;
    logic [31:0] disp_num = 32'h0;
    logic        LCDRS, LCDRW, LCDE, init_done, frame_done;
    logic [3:0]  LCDDAT;

    lcd_hex_driver #(
        .T_POWERUP(20), .T_INIT1(10), .T_INIT2(5), .T_SETUP(1),
        .T_E_HIGH(2), .T_NGAP(2), .T_CMD(4), .T_CLEAR(8)
    ) dut (
        .CCLK(CCLK), .rst(rst), .disp_num(disp_num),
        .LCDRS(LCDRS), .LCDRW(LCDRW), .LCDE(LCDE), .LCDDAT(LCDDAT),
        .init_done(init_done), .frame_done(frame_done)
    );

    always #5 CCLK = ~CCLK;

    typedef struct {
        logic       rs;
        logic [3:0] dat;
        int         rise;
        int         fall;
    } nib_t;

    nib_t       nib_q[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         init_rise = 0;
    int         fd_pulses = 0;
    int         fd_run = 0;
    int         rise_cyc = 0;
    logic       prev_e = 1'b0;
    logic       prev_init = 1'b0;
    logic       hold_rs = 1'b0;
    logic [3:0] hold_dat = 4'h0;
    bit         timed_out = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ASCII of hex digit pos (0 = most significant) of v
    function automatic logic [7:0] hex_char(input logic [31:0] v, input int pos);
        int d;
        d = int'((v >> (28 - 4 * pos)) & 32'hF);
        if (d < 10) return 8'(48 + d);
        else        return 8'(65 + d - 10);
    endfunction

    // bus monitor, sampled on the falling edge
    initial begin
        forever begin
            @(negedge CCLK);
            cyc++;
            chk("lcdrw_zero", 32'(LCDRW), 32'd0);
            if (rst) begin
                nib_q.delete();
                prev_e    = 1'b0;
                prev_init = 1'b0;
                init_rise = 0;
                fd_pulses = 0;
                fd_run    = 0;
            end else begin
                if (LCDE && !prev_e) begin
                    hold_rs  = LCDRS;
                    hold_dat = LCDDAT;
                    rise_cyc = cyc;
                end else if (LCDE) begin
                    chk("rs_stable_e_high", 32'(LCDRS), 32'(hold_rs));
                    chk("dat_stable_e_high", 32'(LCDDAT), 32'(hold_dat));
                end else if (prev_e) begin
                    chk("rs_held_at_fall", 32'(LCDRS), 32'(hold_rs));
                    chk("dat_held_at_fall", 32'(LCDDAT), 32'(hold_dat));
                    nib_q.push_back('{rs: hold_rs, dat: hold_dat, rise: rise_cyc, fall: cyc});
                end
                prev_e = LCDE;
                if (init_done && !prev_init) init_rise = cyc;
                prev_init = init_done;
                if (frame_done) begin
                    fd_run++;
                end else if (fd_run != 0) begin
                    fd_pulses++;
                    chk("frame_done_width", 32'(fd_run), 32'd1);
                    fd_run = 0;
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

    task automatic get_nib(output nib_t n);
        int waited = 0;
        while (nib_q.size() == 0 && !timed_out && waited < 1000) begin
            @(negedge CCLK);
            #1;
            waited++;
        end
        if (nib_q.size() != 0) begin
            n = nib_q.pop_front();
        end else begin
            if (!timed_out) chk("nibble_timeout", 32'(nib_q.size()), 32'd1);
            timed_out = 1'b1;
            n = '{rs: 1'b0, dat: 4'h0, rise: 0, fall: 0};
        end
    endtask

    task automatic get_byte(output logic rs, output logic [7:0] b, output nib_t hi, output nib_t lo);
        get_nib(hi);
        get_nib(lo);
        chk("byte_rs_pair", 32'(lo.rs), 32'(hi.rs));
        rs = hi.rs;
        b  = {hi.dat, lo.dat};
    endtask

    task automatic do_init(input int rel, output int fall_last);
        nib_t       n, hi, lo;
        logic       rs;
        logic [7:0] b;
        logic [3:0] init_exp [4] = '{4'h3, 4'h3, 4'h3, 4'h2};
        logic [7:0] cfg_exp  [4] = '{8'h28, 8'h06, 8'h0C, 8'h01};
        for (int i = 0; i < 4; i++) begin
            get_nib(n);
            if (i == 0) chk("first_rise_after_powerup", 32'(n.rise - rel >= 21), 32'd1);
            chk($sformatf("init_rs%0d", i), 32'(n.rs), 32'd0);
            chk($sformatf("init_nib%0d", i), 32'(n.dat), 32'(init_exp[i]));
        end
        for (int i = 0; i < 4; i++) begin
            get_byte(rs, b, hi, lo);
            chk($sformatf("cfg_rs%0d", i), 32'(rs), 32'd0);
            chk($sformatf("cfg_byte%0d", i), 32'(b), 32'(cfg_exp[i]));
        end
        fall_last = lo.fall;
    endtask

    // one frame: address command, 8 characters of expv; disp_num is changed
    // to mid_v after the 3rd character and to next_v after the 8th
    task automatic run_frame(input logic [31:0] expv, input logic [31:0] mid_v,
                             input logic [31:0] next_v, input int fb, output int rise80);
        nib_t       hi, lo;
        logic       rs;
        logic [7:0] b;
        get_byte(rs, b, hi, lo);
        chk("addr_rs", 32'(rs), 32'd0);
        chk("addr_cmd", 32'(b), 32'h80);
        chk("frame_done_count", 32'(fd_pulses), 32'(fb));
        rise80 = hi.rise;
        for (int i = 0; i < 8; i++) begin
            get_byte(rs, b, hi, lo);
            chk($sformatf("data_rs%0d", i), 32'(rs), 32'd1);
            chk($sformatf("char%0d_of_%08h", i, expv), 32'(b), 32'(hex_char(expv, i)));
            if (i == 2) disp_num = mid_v;
            if (i == 7) disp_num = next_v;
        end
    endtask

    initial begin
        int          rel, fall12, r80;
        logic [31:0] v_cur, v_next;
        nib_t        hi, lo;
        logic        rs;
        logic [7:0]  b;

        rst      = 1'b1;
        disp_num = 32'h1234ABCD;
        repeat (3) @(posedge CCLK);
        @(negedge CCLK);
        #1;
        chk("rst_lcdrs", 32'(LCDRS), 32'd0);
        chk("rst_lcdrw", 32'(LCDRW), 32'd0);
        chk("rst_lcde", 32'(LCDE), 32'd0);
        chk("rst_lcddat", 32'(LCDDAT), 32'd0);
        chk("rst_init_done", 32'(init_done), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        rst = 1'b0;
        rel = cyc;

        do_init(rel, fall12);
        run_frame(32'h1234ABCD, 32'h1234ABCD, 32'hFFFFFFDB, 0, r80);
        chk("clear_gap_ge_8", 32'(r80 - fall12 >= 8), 32'd1);
        chk("init_done_after_pulse12", 32'(init_rise > fall12 && init_rise < r80), 32'd1);
        run_frame(32'hFFFFFFDB, 32'h00000000, 32'h00000000, 1, r80);
        v_next = $urandom;
        run_frame(32'h00000000, $urandom, v_next, 2, r80);
        for (int f = 3; f < 6; f++) begin
            v_cur  = v_next;
            v_next = $urandom;
            run_frame(v_cur, $urandom, v_next, f, r80);
        end

        // frame interrupted by reset while the 5th character is strobing
        get_byte(rs, b, hi, lo);
        chk("addr_cmd_pre_reset", 32'(b), 32'h80);
        chk("frame_done_count_pre_reset", 32'(fd_pulses), 32'd6);
        for (int i = 0; i < 4; i++) begin
            get_byte(rs, b, hi, lo);
            chk($sformatf("char%0d_pre_reset", i), 32'(b), 32'(hex_char(v_next, i)));
        end
        for (int k = 0; k < 100 && !LCDE; k++) begin
            @(negedge CCLK);
            #1;
        end
        chk("lcde_high_before_reset", 32'(LCDE), 32'd1);
        rst = 1'b1;
        @(negedge CCLK);
        #1;
        chk("reset_lcde_low", 32'(LCDE), 32'd0);
        chk("reset_init_done_low", 32'(init_done), 32'd0);
        v_cur    = $urandom;
        disp_num = v_cur;
        @(negedge CCLK);
        #1;
        rst = 1'b0;
        rel = cyc;

        do_init(rel, fall12);
        run_frame(v_cur, $urandom, v_cur, 0, r80);
        chk("init_done_after_pulse12_again", 32'(init_rise > fall12 && init_rise < r80), 32'd1);
        get_byte(rs, b, hi, lo);
        chk("addr_cmd_final", 32'(b), 32'h80);
        chk("frame_done_count_final", 32'(fd_pulses), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
